// File: rtl/wb_resp_mem.sv
// Wishbone classic-cycle responder: small word-organised register memory with
// programmable wait states, err termination for illegal addresses and optional
// periodic rty termination. All terminations and read data are registered.
module wb_resp_mem #(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DEPTH_LOG2  = 2,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned RETRY_EVERY = 0
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    input  logic [3:0]            wb_sel_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [31:0]             retry_cnt_q, retry_cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic                    we_q, we_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             wdat_q, wdat_d;
    logic [31:0]             mem_q [Depth];
    logic [31:0]             mem_d [Depth];
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rty_q, rty_d;
    logic [31:0]             dat_q, dat_d;

    logic                    req;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    legal;
    logic                    retry_hit;

    assign req       = wb_cyc_i & wb_stb_i;
    assign idx       = adr_q[DEPTH_LOG2+1:2];
    // Word aligned and nothing set above the implemented word range.
    assign legal     = (adr_q[1:0] == 2'b00) && ((adr_q >> (DEPTH_LOG2 + 2)) == '0);
    assign retry_hit = (RETRY_EVERY != 0) && (retry_cnt_q == RETRY_EVERY - 1);

    // Next-state, termination decode and memory update.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        retry_cnt_d = retry_cnt_q;
        adr_d       = adr_q;
        we_d        = we_q;
        sel_d       = sel_q;
        wdat_d      = wdat_q;
        mem_d       = mem_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rty_d       = 1'b0;
        dat_d       = '0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    adr_d      = wb_adr_i;
                    we_d       = wb_we_i;
                    sel_d      = wb_sel_i;
                    wdat_d     = wb_dat_i;
                    wait_cnt_d = 4'(WAIT_STATES);
                    state_d    = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (!req) begin
                    // Master abandoned the cycle: drop it silently.
                    state_d = StIdle;
                end else if (wait_cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
                if (!legal) begin
                    err_d = 1'b1;
                end else if (retry_hit) begin
                    rty_d       = 1'b1;
                    retry_cnt_d = '0;
                end else begin
                    ack_d = 1'b1;
                    if (RETRY_EVERY != 0) begin
                        retry_cnt_d = retry_cnt_q + 32'd1;
                    end
                    if (we_q) begin
                        for (int k = 0; k < 4; k++) begin
                            if (sel_q[k]) begin
                                mem_d[idx][8*k +: 8] = wdat_q[8*k +: 8];
                            end
                        end
                    end else begin
                        dat_d = mem_q[idx];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters, latched request, memory and registered outputs.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            retry_cnt_q <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            wdat_q      <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rty_q       <= 1'b0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            wdat_q      <= wdat_d;
            mem_q       <= mem_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rty_q       <= rty_d;
            dat_q       <= dat_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = rty_q;
    assign wb_dat_o = dat_q;

endmodule

// File: doc/wb_resp_mem.md
# wb_resp_mem

Wishbone classic-cycle responder: a small word-organised register memory with programmable wait states, error termination for illegal addresses, and optional periodic retry termination. It is the slave-side counterpart of the bench Wishbone master (`wb_mast`) used to drive `uart_top`. It lets the master's `err`/`rty`/wait-state paths be exercised in simulation, and it can act as a scratch register bank on the same 5-bit UART-style address bus.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: byte-address width of `wb_adr_i`; must be ≥ `DEPTH_LOG2`+2
- `DEPTH_LOG2`, 2: log2 of word count (default 4 words, byte addresses 0..15)
- `WAIT_STATES`, 1: extra cycles inserted before termination (0..15)
- `RETRY_EVERY`, 0: every Nth legal transaction terminates with `rty`; 0 disables

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `wb_rst_i`  in  1  reset; asynchronous, active-high
- `wb_adr_i`  in  `ADDR_WIDTH`  byte address
- `wb_dat_i`  in  32  write data
- `wb_dat_o`  out  32  read data; valid only while `wb_ack_o`=1, else 0
- `wb_we_i`  in  1  1=write, 0=read
- `wb_stb_i`  in  1  strobe
- `wb_cyc_i`  in  1  cycle valid
- `wb_sel_i`  in  4  byte lane enables; bit k ↔ `wb_dat_i[8k+7:8k]`
- `wb_ack_o`  out  1  normal termination
- `wb_err_o`  out  1  error termination
- `wb_rty_o`  out  1  retry termination

## Operation
- Word index = `wb_adr_i[DEPTH_LOG2+1:2]`.
- Legal address: `wb_adr_i[1:0]`==0 and all bits above `DEPTH_LOG2+1` are 0. Anything else is illegal.
- State machine IDLE → WAIT → RESP → IDLE:
  - IDLE: when `wb_cyc_i & wb_stb_i`, latch address, we, sel and write data. Load the wait counter with `WAIT_STATES`. Go to WAIT, or to RESP if `WAIT_STATES`=0.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
  - RESP: exactly one of ack/err/rty is high for one cycle. Next state is IDLE.
- Termination priority: illegal address → `err`; else retry hit → `rty`; else `ack`.
- Write effect: occurs only on an `ack` cycle. Only lanes with `sel`=1 are updated. `sel`=0000 still acks with no change.
- `err` and `rty` cycles never modify memory.
- Reads: full 32-bit word is returned regardless of `sel`, driven on `wb_dat_o` only during the ack cycle.
- Retry counter:
  - Counts legal terminations modulo `RETRY_EVERY`. When the count equals `RETRY_EVERY`-1, that transaction gets `rty` and the counter wraps to 0.
  - Illegal (err) transactions do not advance it.
  - Inactive when `RETRY_EVERY`=0.
- Abort: if `wb_cyc_i` or `wb_stb_i` falls while in WAIT, return to IDLE. No termination, no write, retry counter unchanged.
- Back-to-back: if strobe is still high in IDLE after RESP, a new transaction starts (master-held strobe is treated as a new request).

## Timing
- Request sampled at edge N in IDLE → termination high from edge N+1+`WAIT_STATES` to the following edge.
  - Default: ack in cycle N+2.
- Terminations and `wb_dat_o` are registered; no combinational path from inputs to outputs.
- Write data is committed at the edge ending the ack cycle. A read issued on the next transaction sees the new value.
- Reset (asynchronous, any state):
  - ack/err/rty = 0, `wb_dat_o` = 0, state IDLE.
  - Wait and retry counters = 0; all memory words = 0.
  - An in-flight transaction is dropped without termination.
- At most one of ack/err/rty is high in any cycle. None are high outside RESP.

## Test plan
- Reset, read addr 0x00 (`WAIT_STATES`=1) → ack exactly 2 cycles after strobe sampled, `wb_dat_o`=0x00000000, err=rty=0.
- Write 0x11223344 sel=1111 to 0x04, read 0x04 → 0x11223344. Write 0xAB000000 sel=1000 to 0x04, read → 0xAB223344.
- Read 0x10 and 0x02 → `wb_err_o` one cycle each, no ack. Preceding read of 0x04 still returns 0xAB223344.
- `RETRY_EVERY`=3: write 0x1/0x2/0x3 to 0x08 → ack, ack, rty. Read 0x08 → 0x00000002. A fourth write then acks.
- Drop `wb_stb_i` during WAIT of a write 0xDEADBEEF to 0x0C → no termination. Read 0x0C → 0x00000000. Next transaction terminates normally.
- Assert `wb_rst_i` mid-WAIT after memory is loaded → all outputs 0 immediately, no termination. Subsequent reads of 0x00..0x0C return 0.
